// File: rtl/inst_enc_pkg.sv
// Shared definitions for the instruction encoder: format codes, the NOP
// word substituted for rejected requests, immediate range limits and the
// FIFO payload layout.
package inst_enc_pkg;

    typedef enum logic [2:0] {
        FMT_I = 3'd0,
        FMT_S = 3'd1,
        FMT_B = 3'd2,
        FMT_U = 3'd3,
        FMT_J = 3'd4,
        FMT_R = 3'd5
    } fmt_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic signed [31:0] IMM_IS_MIN = -32'sd2048;
    localparam logic signed [31:0] IMM_IS_MAX = 32'sd2047;
    localparam logic signed [31:0] IMM_B_MIN  = -32'sd4096;
    localparam logic signed [31:0] IMM_B_MAX  = 32'sd4094;
    localparam logic signed [31:0] IMM_J_MIN  = -32'sd1048576;
    localparam logic signed [31:0] IMM_J_MAX  = 32'sd1048574;

    // Payload carried per FIFO entry: {inst, addr, err}
    localparam int PAYLOAD_W = 65;

    function automatic logic in_range(input logic signed [31:0] v,
                                      input logic signed [31:0] lo,
                                      input logic signed [31:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/inst_enc_fifo.sv
// Two-entry output FIFO holding encoded words with their address tag and
// reject flag. The head payload reads as zero whenever the FIFO is empty.
module inst_enc_fifo
    import inst_enc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [PAYLOAD_W-1:0] push_data,
    input  logic                 pop,
    output logic                 full,
    output logic                 empty,
    output logic [PAYLOAD_W-1:0] head_data
);

    logic [PAYLOAD_W-1:0] mem [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           count;
    logic                 push_ok;
    logic                 pop_ok;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage, pointers and occupancy; reset drops every queued entry
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Present the head entry, or zeros when nothing is queued
    always_comb begin
        head_data = '0;
        if (!empty) begin
            head_data = mem[rd_ptr];
        end
    end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: packs request fields into a 32-bit instruction word,
// substitutes a NOP for out-of-range requests, tags each word with a running
// instruction-memory address and queues it in a 2-entry output FIFO.
module inst_encoder
    import inst_enc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_fmt,
    input  logic [6:0]  req_opcode,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [2:0]  req_funct3,
    input  logic [6:0]  req_funct7,
    input  logic [31:0] req_imm,
    input  logic        base_load,
    input  logic [31:0] base_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic [7:0]  err_cnt
);

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 accept;
    logic                 pop;
    logic [31:0]          enc_inst;
    logic                 enc_reject;
    logic [31:0]          push_inst;
    logic [31:0]          tag_addr;
    logic [31:0]          addr_cnt;
    logic signed [31:0]   imm_s;
    logic [PAYLOAD_W-1:0] head_data;

    assign imm_s     = req_imm;
    assign req_ready = !rst && !fifo_full;
    assign accept    = req_valid && req_ready;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign push_inst = enc_reject ? NOP_INST : enc_inst;
    assign tag_addr  = base_load ? base_addr : addr_cnt;

    // Field packing and legality check for the requested format
    always_comb begin
        enc_inst   = NOP_INST;
        enc_reject = 1'b0;
        case (req_fmt)
            FMT_I: begin
                enc_inst   = {req_imm[11:0], req_rs1, req_funct3, req_rd, req_opcode};
                enc_reject = !in_range(imm_s, IMM_IS_MIN, IMM_IS_MAX);
            end
            FMT_S: begin
                enc_inst   = {req_imm[11:5], req_rs2, req_rs1, req_funct3,
                              req_imm[4:0], req_opcode};
                enc_reject = !in_range(imm_s, IMM_IS_MIN, IMM_IS_MAX);
            end
            FMT_B: begin
                enc_inst   = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                              req_imm[4:1], req_imm[11], req_opcode};
                enc_reject = !in_range(imm_s, IMM_B_MIN, IMM_B_MAX) || req_imm[0];
            end
            FMT_U: begin
                enc_inst   = {req_imm[31:12], req_rd, req_opcode};
                enc_reject = (req_imm[11:0] != 12'd0);
            end
            FMT_J: begin
                enc_inst   = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                              req_rd, req_opcode};
                enc_reject = !in_range(imm_s, IMM_J_MIN, IMM_J_MAX) || req_imm[0];
            end
            FMT_R: begin
                enc_inst   = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, req_opcode};
                enc_reject = 1'b0;
            end
            default: begin
                enc_inst   = NOP_INST;
                enc_reject = 1'b1;
            end
        endcase
    end

    // Address counter: a same-cycle base_load retags the pushed word itself
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_cnt <= 32'd0;
        end else if (accept) begin
            addr_cnt <= tag_addr + 32'd4;
        end else if (base_load) begin
            addr_cnt <= base_addr;
        end
    end

    // Saturating count of rejected accepts
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= 8'd0;
        end else if (accept && enc_reject && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    inst_enc_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data ({push_inst, tag_addr, enc_reject}),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (head_data)
    );

    assign out_inst = head_data[64:33];
    assign out_addr = head_data[32:1];
    assign out_err  = head_data[0];

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: a scoreboard queue holds the words
// the encoder should emit, filled when a request is accepted and drained as
// the DUT presents words with out_ready high.
module tb_inst_encoder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_fmt;
    logic [6:0]  req_opcode;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [2:0]  req_funct3;
    logic [6:0]  req_funct7;
    logic [31:0] req_imm;
    logic        base_load;
    logic [31:0] base_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        out_err;
    logic [7:0]  err_cnt;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
        logic [2:0]  fmt;
        logic [31:0] imm;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_addr   = 32'd0;
    int          m_err    = 0;

    inst_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_fmt    (req_fmt),
        .req_opcode (req_opcode),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_funct3 (req_funct3),
        .req_funct7 (req_funct7),
        .req_imm    (req_imm),
        .base_load  (base_load),
        .base_addr  (base_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_addr   (out_addr),
        .out_err    (out_err),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder written directly from the field tables
    function automatic void model_encode(input logic [2:0] fmt, input logic [6:0] op,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic [31:0] imm,
                                         output logic [31:0] inst, output logic err);
        longint v;
        v    = longint'($signed(imm));
        inst = 32'h0000_0013;
        err  = 1'b0;
        case (fmt)
            3'd0: begin
                err  = (v < -2048) || (v > 2047);
                inst = {imm[11:0], rs1, f3, rd, op};
            end
            3'd1: begin
                err  = (v < -2048) || (v > 2047);
                inst = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            end
            3'd2: begin
                err  = (v < -4096) || (v > 4094) || imm[0];
                inst = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            end
            3'd3: begin
                err  = (imm[11:0] != 12'd0);
                inst = {imm[31:12], rd, op};
            end
            3'd4: begin
                err  = (v < -1048576) || (v > 1048574) || imm[0];
                inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            end
            3'd5: begin
                err  = 1'b0;
                inst = {f7, rs2, rs1, f3, rd, op};
            end
            default: err = 1'b1;
        endcase
        if (err) inst = 32'h0000_0013;
    endfunction

    // Immediate generator as a core decoder would see it
    function automatic logic [31:0] decode_imm(input logic [2:0] fmt, input logic [31:0] w);
        case (fmt)
            3'd0:    return {{20{w[31]}}, w[31:20]};
            3'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
            3'd2:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3'd3:    return {w[31:12], 12'd0};
            3'd4:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare handshake, error count and head word against the scoreboard
    task automatic checkOutput();
        logic model_ready;
        model_ready = !rst && (sb.size() < 2);
        check("req_ready", {31'd0, req_ready}, {31'd0, model_ready});
        check("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
        check("err_cnt", {24'd0, err_cnt}, 32'(m_err));
        if (sb.size() != 0) begin
            check("out_inst", out_inst, sb[0].inst);
            check("out_addr", out_addr, sb[0].addr);
            check("out_err", {31'd0, out_err}, {31'd0, sb[0].err});
            if (!sb[0].err && sb[0].fmt <= 3'd4) begin
                check("imm_roundtrip", decode_imm(sb[0].fmt, out_inst), sb[0].imm);
            end
        end
    endtask

    // One clock cycle with the currently driven inputs, scoreboard updated
    task automatic applyStimulus();
        logic        acc;
        logic        pop;
        exp_t        e;
        logic [31:0] tag;
        #1;
        checkOutput();
        acc = req_valid && !rst && (sb.size() < 2);
        pop = (sb.size() != 0) && out_ready;
        tag = base_load ? base_addr : m_addr;
        model_encode(req_fmt, req_opcode, req_rd, req_rs1, req_rs2, req_funct3,
                     req_funct7, req_imm, e.inst, e.err);
        e.addr = tag;
        e.fmt  = req_fmt;
        e.imm  = req_imm;
        @(posedge clk);
        #1;
        if (rst) begin
            sb.delete();
            m_addr = 32'd0;
            m_err  = 0;
        end else begin
            if (pop) void'(sb.pop_front());
            if (acc) begin
                sb.push_back(e);
                m_addr = tag + 32'd4;
                if (e.err && m_err < 255) m_err++;
            end else if (base_load) begin
                m_addr = base_addr;
            end
        end
    endtask

    task automatic drive_req(input logic [2:0] fmt, input logic [6:0] op,
                             input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [31:0] imm);
        req_valid  = 1'b1;
        req_fmt    = fmt;
        req_opcode = op;
        req_rd     = rd;
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_funct3 = f3;
        req_funct7 = f7;
        req_imm    = imm;
    endtask

    task automatic idle();
        req_valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  fmt;
        logic [31:0] imm;
    } bnd_t;

    bnd_t bounds[$] = '{
        '{3'd0, 32'd2047},       '{3'd0, 32'd2048},
        '{3'd0, 32'hFFFF_F800},  '{3'd0, 32'hFFFF_F7FF},
        '{3'd1, 32'd2047},       '{3'd1, 32'hFFFF_F7FF},
        '{3'd2, 32'd4094},       '{3'd2, 32'hFFFF_F000},
        '{3'd2, 32'd4096},       '{3'd4, 32'd1048574},
        '{3'd4, 32'hFFF0_0000},  '{3'd4, 32'd3},
        '{3'd3, 32'h1234_5000},  '{3'd3, 32'h1234_5001},
        '{3'd6, 32'd0},          '{3'd7, 32'd0}
    };

    initial begin
        logic [31:0] tmp;
        logic [2:0]  f;
        logic [31:0] imm;

        rst       = 1'b1;
        out_ready = 1'b1;
        base_load = 1'b0;
        base_addr = 32'd0;
        drive_req(3'd5, 7'h33, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        idle();
        @(posedge clk);
        #1;
        applyStimulus();

        $display("[TB] reset state");
        req_valid = 1'b1;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_out_addr", out_addr, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        applyStimulus();
        check("rst_no_accept", {31'd0, out_valid}, 32'd0);
        idle();
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, req_ready}, 32'd1);

        $display("[TB] directed encodings");
        drive_req(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        applyStimulus();
        idle();
        #1;
        check("i_inst", out_inst, 32'hFFF0_0093);
        check("i_addr", out_addr, 32'd0);
        check("i_err", {31'd0, out_err}, 32'd0);
        applyStimulus();

        drive_req(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
        applyStimulus();
        idle();
        #1;
        check("b_inst", out_inst, 32'h0020_8463);
        applyStimulus();
        drive_req(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7);
        applyStimulus();
        idle();
        #1;
        check("b_odd_inst", out_inst, 32'h0000_0013);
        check("b_odd_err", {31'd0, out_err}, 32'd1);
        check("b_odd_cnt", {24'd0, err_cnt}, 32'd1);
        applyStimulus();

        drive_req(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        applyStimulus();
        idle();
        #1;
        check("j_inst", out_inst, 32'h0010_00EF);
        applyStimulus();
        drive_req(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000);
        applyStimulus();
        idle();
        #1;
        check("j_far_err", {31'd0, out_err}, 32'd1);
        check("j_far_inst", out_inst, 32'h0000_0013);
        applyStimulus();

        $display("[TB] backpressure and ordering");
        base_load = 1'b1;
        base_addr = 32'd0;
        applyStimulus();
        base_load = 1'b0;
        out_ready = 1'b0;
        drive_req(3'd5, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0);
        applyStimulus();
        drive_req(3'd5, 7'h33, 5'd4, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
        applyStimulus();
        drive_req(3'd5, 7'h33, 5'd5, 5'd1, 5'd2, 3'd7, 7'h00, 32'd0);
        #1;
        check("full_ready", {31'd0, req_ready}, 32'd0);
        check("full_head_addr", out_addr, 32'd0);
        applyStimulus();
        out_ready = 1'b1;
        applyStimulus();
        applyStimulus();
        idle();
        #1;
        check("third_addr", out_addr, 32'd8);
        applyStimulus();

        $display("[TB] base_load with push and address wrap");
        base_load = 1'b1;
        base_addr = 32'hFFFF_FFFC;
        drive_req(3'd5, 7'h33, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        applyStimulus();
        base_load = 1'b0;
        drive_req(3'd5, 7'h33, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        #1;
        check("wrap_first", out_addr, 32'hFFFF_FFFC);
        applyStimulus();
        idle();
        applyStimulus();
        check("wrap_second", out_addr, 32'h0000_0000);
        applyStimulus();

        $display("[TB] reset with queued entries");
        out_ready = 1'b0;
        drive_req(3'd1, 7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'd16);
        applyStimulus();
        applyStimulus();
        idle();
        rst = 1'b1;
        applyStimulus();
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_cnt", {24'd0, err_cnt}, 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        applyStimulus();

        $display("[TB] immediate boundaries");
        foreach (bounds[i]) begin
            drive_req(bounds[i].fmt, 7'h13, 5'd9, 5'd10, 5'd11, 3'd1, 7'd0, bounds[i].imm);
            applyStimulus();
        end
        idle();
        applyStimulus();

        $display("[TB] random round trip");
        for (int i = 0; i < 60; i++) begin
            f   = 3'($urandom_range(0, 4));
            tmp = $urandom();
            case (f)
                3'd0, 3'd1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                3'd2:       imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
                3'd3:       imm = {tmp[19:0], 12'd0};
                default:    imm = (32'($urandom_range(0, 1048575)) - 32'd524288) << 1;
            endcase
            if ($urandom_range(0, 7) == 0) imm = imm ^ 32'd1;
            drive_req(f, 7'($urandom()), 5'($urandom()), 5'($urandom()), 5'($urandom()),
                      3'($urandom()), 7'($urandom()), imm);
            out_ready = 1'($urandom_range(0, 3) != 0);
            base_load = 1'($urandom_range(0, 9) == 0);
            base_addr = {tmp[31:2], 2'b00};
            applyStimulus();
        end
        idle();
        base_load = 1'b0;
        out_ready = 1'b1;
        applyStimulus();
        applyStimulus();
        applyStimulus();

        $display("[TB] error counter saturation");
        drive_req(3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        for (int i = 0; i < 262; i++) begin
            applyStimulus();
        end
        idle();
        applyStimulus();
        check("err_sat", {24'd0, err_cnt}, 32'd255);
        applyStimulus();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have the following ports (name  direction  width  meaning), clock and reset first:
clk  in  1  single clock; all state updates on its rising edge
rst  in  1  reset, synchronous, active-high
req_valid  in  1  encode request present
req_ready  out  1  encoder can accept a request this cycle
req_fmt  in  3  format code: 0=I, 1=S, 2=B, 3=U, 4=J, 5=R, 6/7 illegal
req_opcode  in  7  opcode field; passed through unchecked
req_rd  in  5  destination register
req_rs1  in  5  source register 1
req_rs2  in  5  source register 2
req_funct3  in  3  funct3 field
req_funct7  in  7  funct7 field; used for R only
req_imm  in  32  full signed immediate value (byte offset for B/J; full value for U)
base_load  in  1  load the address counter
base_addr  in  32  new address counter value
out_valid  out  1  encoded word available
out_ready  in  1  consumer accepts the word
out_inst  out  32  encoded instruction
out_addr  out  32  target instruction-memory address of out_inst
out_err  out  1  the word was rejected and replaced by a NOP
err_cnt  out  8  saturating count of rejected requests

Function
REQ-002 SHALL accept a request on a clock edge where req_valid and req_ready are both 1; the request SHALL be encoded combinationally and pushed into a 2-entry output FIFO.
REQ-003 SHALL drive req_ready = 1 when FIFO occupancy is less than 2, and independently of out_ready. A push and pop in the same cycle at occupancy 1 SHALL leave occupancy at 1.
REQ-004 SHALL drive out_valid = 1 whenever the FIFO is not empty; the head pops when out_valid and out_ready are both 1. Latency from accept to out_valid is 1 cycle. Output order is accept order.
REQ-005 SHALL pack the fields as follows:
- I: imm[11:0],rs1,f3,rd,op
- S: imm[11:5],rs2,rs1,f3,imm[4:0],op
- B: imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op
- U: imm[31:12],rd,op
- J: imm[20],imm[10:1],imm[11],imm[19:12],rd,op
- R: f7,rs2,rs1,f3,rd,op
REQ-006 SHALL reject a request when any of the following holds:
- I/S with imm outside [-2048, 2047]
- B with imm outside [-4096, 4094] or imm[0] = 1
- J with imm outside [-1048576, 1048574] or imm[0] = 1
- U with imm[11:0] != 0
- req_fmt of 6 or 7
R never rejects.
REQ-007 SHALL still push a rejected request, with out_inst = 0x00000013 (NOP) and out_err = 1. err_cnt SHALL increment by 1 per rejected accept and saturate at 255.
REQ-008 SHALL tag each pushed entry with the current address counter value, then advance the counter by 4 with modulo-2^32 wrap.
REQ-009 SHALL handle base_load as follows:
- base_load without a push: counter = base_addr.
- base_load together with a push: the entry is tagged base_addr and the counter becomes base_addr + 4.
REQ-010 SHALL NOT let base_load alter entries already in the FIFO.

Reset
REQ-011 SHALL, while rst = 1 at a clock edge, clear the FIFO and set the address counter to 0 and err_cnt to 0. After that edge: out_valid = 0, out_inst = 0, out_addr = 0, out_err = 0, req_ready = 0 while rst is held, and req_ready = 1 in the first cycle after rst deasserts.
REQ-012 SHALL discard FIFO contents when rst asserts mid-operation; requests presented during reset SHALL NOT be accepted.

Structure
REQ-013 SHALL place the format codes, the NOP constant and the immediate range limits in the shared package inst_enc_pkg.
REQ-014 SHALL implement the FIFO as the sub-module inst_enc_fifo (2 entries, 65-bit payload: inst, addr, err).

Verification
REQ-015 SHALL cover: I, op=0x13, rd=1, rs1=0, f3=0, imm=0xFFFFFFFF -> next cycle out_inst=0xFFF00093, out_addr=0, out_err=0.
REQ-016 SHALL cover: B, op=0x63, rs1=1, rs2=2, f3=0, imm=8 -> out_inst=0x00208463; then B with imm=7 -> out_inst=0x00000013, out_err=1, err_cnt=1.
REQ-017 SHALL cover: J, op=0x6F, rd=1, imm=0x800 -> out_inst=0x001000EF; J with imm=0x100000 -> rejected.
REQ-018 SHALL cover: out_ready=0 with 3 back-to-back requests -> req_ready drops after 2 accepts; after out_ready=1, words emerge in order at addresses 0, 4, 8.
REQ-019 SHALL cover: base_load=0xFFFFFFFC concurrent with a push, then one more push -> out_addr 0xFFFFFFFC then 0x00000000.
REQ-020 SHALL cover: rst pulsed with 2 entries queued -> out_valid=0 next cycle, err_cnt=0; random I/S/B/J/U round-trip through the core's immediate generator returns req_imm for every non-rejected word.
